// File: rtl/floatingpoint.sv
// Shared floating-point types plus the arbiter state encoding and default timeout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package floatingpoint;

  // IEEE-754 single precision, field order matches the bit layout
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int FP_ADD_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/float_add_arbiter_if.sv
// Operand/result channel between the arbiter (master) and the shared FloatAdder (slave).
// Latency: wires only.
// Backpressure: none; AddInputValid is a load strobe, AddResultValid a level done flag.
interface float_add_arbiter_if;
  import floatingpoint::*;

  float AddOp1;
  float AddOp2;
  logic AddInputValid;
  float AddResult;
  logic AddResultValid;

  modport master (
    output AddOp1, AddOp2, AddInputValid,
    input  AddResult, AddResultValid
  );

  modport slave (
    input  AddOp1, AddOp2, AddInputValid,
    output AddResult, AddResultValid
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  // scan NREQ positions starting at ptr, keep only the first hit
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/float_add_arbiter.sv
// Shares one FloatAdder among NREQ requesters: grant, issue, wait for result or timeout, respond.
// Latency: grant t, issue t+1, earliest response t+3+BLANK; timeout response TIMEOUT+1 after issue.
// Backpressure: ReqReady only in IDLE; requesters hold ReqValid; responses cannot be stalled.
module float_add_arbiter
  import floatingpoint::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int BLANK   = 2,
  parameter int TIMEOUT = FP_ADD_TIMEOUT_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NREQ-1:0]     ReqValid,
  input  float                ReqOp1 [NREQ],
  input  float                ReqOp2 [NREQ],
  output logic [NREQ-1:0]     ReqReady,
  output logic                RespValid,
  output logic [IDW-1:0]      RespId,
  output float                RespResult,
  output logic                RespError,
  float_add_arbiter_if.master add,
  output logic                Busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  float            res_q, res_d;
  float            op1_q, op1_d;
  float            op2_q, op2_d;

  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  rr_priority_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (ReqValid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // next-state: grant in IDLE, one-cycle issue, blanked wait with timeout, one-cycle response
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_d   = res_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          op1_d   = ReqOp1[pick_idx];
          op2_d   = ReqOp2[pick_idx];
          id_d    = pick_idx;
          ptr_d   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // a qualified result beats a simultaneous timeout
        if (add.AddResultValid && (cnt_q >= CW'(BLANK))) begin
          res_d   = add.AddResult;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, synchronous active-low reset drops any in-flight op
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  // ReqReady is gated by Reset so nothing looks granted while reset is held
  assign ReqReady          = (state_q == IDLE && Reset) ? pick_grant : '0;
  assign RespValid         = (state_q == RESP);
  assign RespId            = id_q;
  assign RespResult        = res_q;
  assign RespError         = err_q;
  assign add.AddOp1        = op1_q;
  assign add.AddOp2        = op2_q;
  assign add.AddInputValid = (state_q == ISSUE);
  assign Busy              = (state_q != IDLE);

endmodule

// File: tb/tb_float_add_arbiter.sv
// Directed bench for float_add_arbiter with a behavioural adder model and event monitors.
// Latency: adder model latency and stale-valid hold are set per test.
// Backpressure: requesters hold ReqValid until granted; responses are logged every cycle.
module tb_float_add_arbiter;
  import floatingpoint::*;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int BLANK   = 2;
  localparam int TIMEOUT = 16;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic [NREQ-1:0] ReqValid = '0;
  float            ReqOp1 [NREQ];
  float            ReqOp2 [NREQ];
  logic [NREQ-1:0] ReqReady;
  logic            RespValid;
  logic [IDW-1:0]  RespId;
  float            RespResult;
  logic            RespError;
  logic            Busy;

  float_add_arbiter_if ai ();

  float_add_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .BLANK(BLANK), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqOp1     (ReqOp1),
    .ReqOp2     (ReqOp2),
    .ReqReady   (ReqReady),
    .RespValid  (RespValid),
    .RespId     (RespId),
    .RespResult (RespResult),
    .RespError  (RespError),
    .add        (ai),
    .Busy       (Busy)
  );

  initial forever #5 Clock = ~Clock;

  int cyc = 0;
  initial forever begin
    @(posedge Clock);
    cyc++;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // positive-normal single-precision add, truncating, enough for the directed operands
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex, ey;
    logic [24:0] mx, my, s;
    int          d;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = x[30:23];
    ey = y[30:23];
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    d  = int'(ex) - int'(ey);
    my = (d < 25) ? (my >> d) : '0;
    s  = mx + my;
    if (s[24]) begin
      s  = s >> 1;
      ex = ex + 8'd1;
    end
    return {1'b0, ex, s[22:0]};
  endfunction

  // adder model: stale valid held mdl_hold cycles after issue, new result at mdl_lat (<0: never)
  int          mdl_hold = -1;
  int          mdl_lat  = 1;
  int          age      = 0;
  bit          active   = 1'b0;
  logic [31:0] pend     = '0;

  initial begin
    ai.AddResultValid = 1'b0;
    ai.AddResult      = '0;
    forever begin
      @(negedge Clock);
      if (ai.AddInputValid) begin
        age    = 0;
        active = 1'b1;
        pend   = fadd(ai.AddOp1, ai.AddOp2);
      end else if (active) begin
        age++;
      end
      if (active) begin
        if (mdl_lat >= 0 && age >= mdl_lat) begin
          ai.AddResult      = pend;
          ai.AddResultValid = 1'b1;
          active            = 1'b0;
        end else if (age > mdl_hold) begin
          ai.AddResultValid = 1'b0;
        end
      end
    end
  end

  // event logs
  logic [3:0]  gnt_v [$];
  int          gnt_c [$];
  int          iss_c [$];
  logic [31:0] iss_op1 [$];
  logic [31:0] iss_op2 [$];
  logic [1:0]  rsp_id [$];
  logic [31:0] rsp_res [$];
  logic        rsp_err [$];
  int          rsp_c [$];
  int          outstanding = 0;

  initial forever begin
    @(negedge Clock);
    if (!Reset) outstanding = 0;
    if (|(ReqReady & ReqValid)) begin
      gnt_v.push_back(ReqReady);
      gnt_c.push_back(cyc);
    end
    if (ai.AddInputValid) begin
      check("one_in_flight", 64'(outstanding), 64'd0);
      outstanding = 1;
      iss_c.push_back(cyc);
      iss_op1.push_back(ai.AddOp1);
      iss_op2.push_back(ai.AddOp2);
    end
    if (RespValid) begin
      outstanding = 0;
      rsp_id.push_back(RespId);
      rsp_res.push_back(RespResult);
      rsp_err.push_back(RespError);
      rsp_c.push_back(cyc);
    end
  end

  task automatic clear_q();
    gnt_v.delete(); gnt_c.delete(); iss_c.delete(); iss_op1.delete(); iss_op2.delete();
    rsp_id.delete(); rsp_res.delete(); rsp_err.delete(); rsp_c.delete();
  endtask

  // wait until n grants are logged (bounded), then return just after the next posedge
  task automatic wait_grant(input int n);
    for (int i = 0; i < 200 && gnt_v.size() < n; i++) @(negedge Clock);
    check("grant_seen", 64'(gnt_v.size() >= n), 64'd1);
    @(posedge Clock);
    #1;
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_ReqReady"},      64'(ReqReady), 64'd0);
    check({pfx, "_Busy"},          64'(Busy), 64'd0);
    check({pfx, "_RespValid"},     64'(RespValid), 64'd0);
    check({pfx, "_RespId"},        64'(RespId), 64'd0);
    check({pfx, "_RespResult"},    64'(RespResult), 64'd0);
    check({pfx, "_RespError"},     64'(RespError), 64'd0);
    check({pfx, "_AddOp1"},        64'(ai.AddOp1), 64'd0);
    check({pfx, "_AddOp2"},        64'(ai.AddOp2), 64'd0);
    check({pfx, "_AddInputValid"}, 64'(ai.AddInputValid), 64'd0);
  endtask

  logic [31:0] exp_sum [NREQ];
  logic [3:0]  oh;

  initial begin
    // r0: 1+1=2, r1: 1+2=3, r2: 2+2=4, r3: 2+4=6
    ReqOp1[0] = 32'h3F800000; ReqOp2[0] = 32'h3F800000; exp_sum[0] = 32'h40000000;
    ReqOp1[1] = 32'h3F800000; ReqOp2[1] = 32'h40000000; exp_sum[1] = 32'h40400000;
    ReqOp1[2] = 32'h40000000; ReqOp2[2] = 32'h40000000; exp_sum[2] = 32'h40800000;
    ReqOp1[3] = 32'h40000000; ReqOp2[3] = 32'h40800000; exp_sum[3] = 32'h40C00000;

    // reset held with a pending request: everything must read zero
    Reset    = 1'b0;
    ReqValid = 4'b0001;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_idle_zero("reset");
    @(posedge Clock);
    #1;
    ReqValid = '0;
    Reset    = 1'b1;

    // single request from requester 1: 1.0 + 2.0
    clear_q();
    ReqValid = 4'b0010;
    wait_grant(1);
    ReqValid = '0;
    repeat (12) @(posedge Clock);
    #1;
    check("single_grants",  64'(gnt_v.size()), 64'd1);
    check("single_ready",   64'(gnt_v[0]), 64'b0010);
    check("single_issues",  64'(iss_c.size()), 64'd1);
    check("single_issue_t", 64'(iss_c[0] - gnt_c[0]), 64'd1);
    check("single_op1",     64'(iss_op1[0]), 64'h3F800000);
    check("single_op2",     64'(iss_op2[0]), 64'h40000000);
    check("single_resps",   64'(rsp_id.size()), 64'd1);
    check("single_id",      64'(rsp_id[0]), 64'd1);
    check("single_res",     64'(rsp_res[0]), 64'h40400000);
    check("single_err",     64'(rsp_err[0]), 64'd0);
    check("single_lat",     64'(rsp_c[0] - gnt_c[0]), 64'(BLANK + 3));

    // requester 0 granted, adder never answers, reset lands mid-WAIT
    mdl_lat  = -1;
    mdl_hold = -1;
    clear_q();
    ReqValid = 4'b0001;
    wait_grant(1);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("midwait_busy", 64'(Busy), 64'd1);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check_idle_zero("midreset");
    @(posedge Clock);
    #1;
    check("midreset_no_resp", 64'(rsp_id.size()), 64'd0);

    // release with all four held: order 0,1,2,3,0 shows Ptr restarted at 0
    clear_q();
    mdl_lat  = 1;
    Reset    = 1'b1;
    ReqValid = 4'b1111;
    wait_grant(5);
    ReqValid = '0;
    repeat (15) @(posedge Clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      check($sformatf("rr_grant%0d", i), 64'(gnt_v[i]), 64'(oh));
    end
    check("rr_resps", 64'(rsp_id.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_id%0d", i),  64'(rsp_id[i]), 64'(i % 4));
      check($sformatf("rr_res%0d", i), 64'(rsp_res[i]), 64'(exp_sum[i % 4]));
    end

    // stale valid from the previous op (2.0) held through blanking, new result 5 after issue
    mdl_hold = 2;
    mdl_lat  = 5;
    clear_q();
    ReqValid = 4'b0100;
    wait_grant(1);
    ReqValid = '0;
    repeat (15) @(posedge Clock);
    #1;
    check("stale_resps", 64'(rsp_id.size()), 64'd1);
    check("stale_id",    64'(rsp_id[0]), 64'd2);
    check("stale_res",   64'(rsp_res[0]), 64'h40800000);
    check("stale_err",   64'(rsp_err[0]), 64'd0);
    check("stale_lat",   64'(rsp_c[0] - iss_c[0]), 64'd6);

    // adder silent: timeout declared on the TIMEOUT-th cycle after issue, response next cycle
    mdl_hold = -1;
    mdl_lat  = -1;
    clear_q();
    ReqValid = 4'b1000;
    wait_grant(1);
    ReqValid = '0;
    repeat (TIMEOUT + 8) @(posedge Clock);
    #1;
    check("tmo_resps", 64'(rsp_id.size()), 64'd1);
    check("tmo_id",    64'(rsp_id[0]), 64'd3);
    check("tmo_err",   64'(rsp_err[0]), 64'd1);
    check("tmo_res",   64'(rsp_res[0]), 64'd0);
    check("tmo_lat",   64'(rsp_c[0] - iss_c[0]), 64'(TIMEOUT + 1));

    // r0 served with Ptr=1 while r2 and r3 wait; r2 withdraws, so 3 then 0
    mdl_lat = 1;
    clear_q();
    ReqValid = 4'b0001;
    wait_grant(1);
    ReqValid = 4'b1100;
    repeat (2) @(posedge Clock);
    #1;
    ReqValid = 4'b1000;
    wait_grant(2);
    ReqValid = 4'b0001;
    wait_grant(3);
    ReqValid = '0;
    repeat (12) @(posedge Clock);
    #1;
    check("drop_grants", 64'(gnt_v.size()), 64'd3);
    check("drop_g0",     64'(gnt_v[0]), 64'b0001);
    check("drop_g1",     64'(gnt_v[1]), 64'b1000);
    check("drop_g2",     64'(gnt_v[2]), 64'b0001);
    check("drop_resps",  64'(rsp_id.size()), 64'd3);
    check("drop_id1",    64'(rsp_id[1]), 64'd3);
    check("post_tmo_res", 64'(rsp_res[0]), 64'(exp_sum[0]));
    check("post_tmo_err", 64'(rsp_err[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard stop in case a wait above never returns
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
